// File: rtl/icache_resp_collector.sv
// Collects the two 256-bit half-line read beats of each icache load transaction,
// assembles the 512-bit line and emits it to the icache with an ack to the requester.
//
// state | meaning
// IDLE  | waiting for a slot holding both halves; lowest index wins
// EMIT  | line_wr/ack high this cycle; selected slot is released
// GAP   | one-cycle bubble for the icache tag update
module icache_resp_collector #(
    parameter logic [5:0] CORENO = 6'd1,
    parameter logic [5:0] CID    = 6'd0,
    parameter int         ADR_W  = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        resp_v,
    input  logic [5:0]                  resp_core,
    input  logic [5:0]                  resp_channel,
    input  logic [3:0]                  resp_tranid,
    input  logic                        resp_err,
    input  logic [255:0]                resp_dat,
    input  logic [15:0][ADR_W-1:0]      vtags,
    input  logic                        flush,
    output logic                        line_wr,
    output logic [ADR_W-1:0]            line_vadr,
    output logic [511:0]                line_dat,
    output logic                        line_err,
    output logic                        ack,
    output logic [7:0]                  drop_cnt
);

    typedef enum logic [1:0] {IDLE, EMIT, GAP} state_e;

    state_e               state_q, state_d;
    logic [1:0]           sel_q, sel_d;
    logic [3:0]           h0_v_q, h0_v_d, h1_v_q, h1_v_d, err_q, err_d;
    logic [3:0][255:0]    h0_q, h0_d, h1_q, h1_d;
    logic                 line_wr_q, line_wr_d, ack_q, ack_d, line_err_q, line_err_d;
    logic [ADR_W-1:0]     line_vadr_q, line_vadr_d;
    logic [511:0]         line_dat_q, line_dat_d;
    logic [7:0]           drop_cnt_q, drop_cnt_d;

    logic                 id_match, half_v, emitting, beat_ok, beat_bad, found;
    logic [1:0]           slot, pick_idx;
    logic [3:0]           complete;
    logic [ADR_W-1:0]     tag_sel;

    // Only every fourth tag entry and its upper bits are consumed.
    logic unused_vtags;
    assign unused_vtags = ^vtags;

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        h0_v_d      = h0_v_q;
        h1_v_d      = h1_v_q;
        err_d       = err_q;
        h0_d        = h0_q;
        h1_d        = h1_q;
        line_wr_d   = 1'b0;
        ack_d       = 1'b0;
        line_err_d  = line_err_q;
        line_vadr_d = line_vadr_q;
        line_dat_d  = line_dat_q;
        drop_cnt_d  = drop_cnt_q;

        slot     = resp_tranid[3:2];
        id_match = resp_v && (resp_core == CORENO) && (resp_channel == CID);
        half_v   = resp_tranid[0] ? h1_v_q[slot] : h0_v_q[slot];
        emitting = (state_q == EMIT) && (sel_q == slot);
        beat_ok  = id_match && !flush && !resp_tranid[1] && !half_v && !emitting;
        beat_bad = id_match && !flush && (resp_tranid[1] || half_v || emitting);

        complete = h0_v_q & h1_v_q;
        found    = 1'b0;
        pick_idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (complete[i]) begin
                found    = 1'b1;
                pick_idx = 2'(i);
            end
        end
        tag_sel = vtags[{pick_idx, 2'b00}];

        case (state_q)
            IDLE: begin
                if (found && !flush) begin
                    state_d     = EMIT;
                    sel_d       = pick_idx;
                    line_wr_d   = 1'b1;
                    ack_d       = 1'b1;
                    line_dat_d  = {h1_q[pick_idx], h0_q[pick_idx]};
                    line_err_d  = err_q[pick_idx];
                    line_vadr_d = {tag_sel[ADR_W-1:6], 6'd0};
                end
            end
            EMIT: begin
                h0_v_d[sel_q] = 1'b0;
                h1_v_d[sel_q] = 1'b0;
                err_d[sel_q]  = 1'b0;
                state_d       = GAP;
            end
            default: state_d = IDLE;
        endcase

        if (beat_ok) begin
            if (resp_tranid[0]) begin
                h1_d[slot]   = resp_dat;
                h1_v_d[slot] = 1'b1;
            end else begin
                h0_d[slot]   = resp_dat;
                h0_v_d[slot] = 1'b1;
            end
            err_d[slot] = err_q[slot] | resp_err;
        end

        if (flush) begin
            h0_v_d = '0;
            h1_v_d = '0;
            err_d  = '0;
        end

        if (beat_bad && (drop_cnt_q != 8'hFF))
            drop_cnt_d = drop_cnt_q + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            sel_q       <= 2'd0;
            h0_v_q      <= '0;
            h1_v_q      <= '0;
            err_q       <= '0;
            line_wr_q   <= 1'b0;
            ack_q       <= 1'b0;
            line_err_q  <= 1'b0;
            line_vadr_q <= '0;
            line_dat_q  <= '0;
            drop_cnt_q  <= 8'd0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            h0_v_q      <= h0_v_d;
            h1_v_q      <= h1_v_d;
            err_q       <= err_d;
            line_wr_q   <= line_wr_d;
            ack_q       <= ack_d;
            line_err_q  <= line_err_d;
            line_vadr_q <= line_vadr_d;
            line_dat_q  <= line_dat_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    // Half-line data is qualified by the valid bits, so it needs no reset.
    always_ff @(posedge clk) begin
        h0_q <= h0_d;
        h1_q <= h1_d;
    end

    assign line_wr   = line_wr_q;
    assign ack       = ack_q;
    assign line_err  = line_err_q;
    assign line_vadr = line_vadr_q;
    assign line_dat  = line_dat_q;
    assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_icache_resp_collector.sv
// Directed bench for icache_resp_collector: pairing, ordering, latency, drops, flush and reset.
module tb_icache_resp_collector;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 resp_v;
    logic [5:0]           resp_core;
    logic [5:0]           resp_channel;
    logic [3:0]           resp_tranid;
    logic                 resp_err;
    logic [255:0]         resp_dat;
    logic [15:0][31:0]    vtags;
    logic                 flush;
    logic                 line_wr;
    logic [31:0]          line_vadr;
    logic [511:0]         line_dat;
    logic                 line_err;
    logic                 ack;
    logic [7:0]           drop_cnt;

    int checks = 0;
    int errors = 0;

    logic [255:0] d_a, d_b, d_c, d_d, d_e, d_f, d_g, d_h;

    icache_resp_collector #(.CORENO(6'd1), .CID(6'd0), .ADR_W(32)) dut (
        .clk(clk), .rst(rst), .resp_v(resp_v), .resp_core(resp_core),
        .resp_channel(resp_channel), .resp_tranid(resp_tranid), .resp_err(resp_err),
        .resp_dat(resp_dat), .vtags(vtags), .flush(flush), .line_wr(line_wr),
        .line_vadr(line_vadr), .line_dat(line_dat), .line_err(line_err), .ack(ack),
        .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Presents one beat for one cycle; called and returns at a negedge.
    task automatic beat(input logic [5:0] core, input logic [3:0] tid, input logic err,
                        input logic [255:0] dat, input logic fl);
        resp_v       = 1'b1;
        resp_core    = core;
        resp_channel = 6'd0;
        resp_tranid  = tid;
        resp_err     = err;
        resp_dat     = dat;
        flush        = fl;
        tick();
        resp_v = 1'b0;
        flush  = 1'b0;
    endtask

    task automatic no_write(input int n, input string tag);
        logic seen;
        seen = 1'b0;
        repeat (n) begin
            if (line_wr || ack) seen = 1'b1;
            tick();
        end
        chk(tag, seen, 1'b0);
    endtask

    initial begin
        d_a = {8{32'hAAAA_AAAA}};
        d_b = {8{32'hBBBB_BBBB}};
        d_c = {8{32'hCCCC_0001}};
        d_d = {8{32'hDDDD_0002}};
        d_e = {8{32'hEEEE_0003}};
        d_f = {8{32'hFFFF_0004}};
        d_g = {8{32'h1234_5678}};
        d_h = {8{32'h9ABC_DEF0}};
        for (int i = 0; i < 16; i++) vtags[i] = 32'hDEAD_0000 + 32'(i);
        vtags[0]  = 32'h0000_4000;
        vtags[4]  = 32'h0000_1040;
        vtags[8]  = 32'h0000_2080;
        vtags[12] = 32'h0000_30C7;
        rst = 1'b1; resp_v = 1'b0; resp_core = 6'd0; resp_channel = 6'd0;
        resp_tranid = 4'd0; resp_err = 1'b0; resp_dat = '0; flush = 1'b0;
        repeat (3) tick();
        chk("rst_line_wr", line_wr, 1'b0);
        chk("rst_ack", ack, 1'b0);
        chk("rst_vadr", line_vadr, 32'h0);
        chk("rst_dat", line_dat, 512'h0);
        chk("rst_err", line_err, 1'b0);
        chk("rst_drop", drop_cnt, 8'h00);
        rst = 1'b0;
        tick();

        // T1: slot1 in order; write lands two cycles after the completing beat
        beat(6'd1, 4'b0100, 1'b0, d_a, 1'b0);
        beat(6'd1, 4'b0101, 1'b0, d_b, 1'b0);
        chk("t1_wr_n1", line_wr, 1'b0);
        tick();
        chk("t1_wr", line_wr, 1'b1);
        chk("t1_ack", ack, 1'b1);
        chk("t1_vadr", line_vadr, 32'h0000_1040);
        chk("t1_dat", line_dat, {d_b, d_a});
        chk("t1_err", line_err, 1'b0);
        tick();
        chk("t1_wr_off", line_wr, 1'b0);
        chk("t1_ack_off", ack, 1'b0);
        chk("t1_vadr_hold", line_vadr, 32'h0000_1040);
        tick();

        // T2: slot2, h1 before h0
        beat(6'd1, 4'b1001, 1'b0, d_d, 1'b0);
        beat(6'd1, 4'b1000, 1'b0, d_c, 1'b0);
        chk("t2_wr_n1", line_wr, 1'b0);
        tick();
        chk("t2_wr", line_wr, 1'b1);
        chk("t2_dat", line_dat, {d_d, d_c});
        chk("t2_vadr", line_vadr, 32'h0000_2080);
        tick(); tick();

        // T3: interleaved slots; slot2 completes first, slot1 follows three cycles later
        beat(6'd1, 4'b0100, 1'b0, d_e, 1'b0);
        beat(6'd1, 4'b1000, 1'b0, d_f, 1'b0);
        beat(6'd1, 4'b1001, 1'b0, d_g, 1'b0);
        beat(6'd1, 4'b0101, 1'b0, d_h, 1'b0);
        chk("t3_first_wr", line_wr, 1'b1);
        chk("t3_first_dat", line_dat, {d_g, d_f});
        chk("t3_first_vadr", line_vadr, 32'h0000_2080);
        tick();
        chk("t3_gap", line_wr, 1'b0);
        tick();
        chk("t3_idle", line_wr, 1'b0);
        tick();
        chk("t3_second_wr", line_wr, 1'b1);
        chk("t3_second_dat", line_dat, {d_h, d_e});
        chk("t3_second_vadr", line_vadr, 32'h0000_1040);
        tick(); tick();

        // T4: mismatch ignored, bad half and duplicate counted
        beat(6'd2, 4'b0110, 1'b0, d_a, 1'b0);
        beat(6'd1, 4'b0110, 1'b0, d_a, 1'b0);
        beat(6'd1, 4'b0000, 1'b0, d_a, 1'b0);
        beat(6'd1, 4'b0000, 1'b0, d_c, 1'b0);
        no_write(4, "t4_no_write");
        chk("t4_drop", drop_cnt, 8'd2);
        beat(6'd1, 4'b0001, 1'b0, d_b, 1'b0);
        tick();
        chk("t4_slot0_wr", line_wr, 1'b1);
        chk("t4_slot0_dat", line_dat, {d_b, d_a});
        chk("t4_slot0_vadr", line_vadr, 32'h0000_4000);
        beat(6'd1, 4'b0000, 1'b0, d_g, 1'b0);   // hits the slot being emitted
        chk("t4_drop_emit", drop_cnt, 8'd3);
        no_write(5, "t4_emit_beat_lost");

        // T5: error half still written, vadr low bits forced to zero
        beat(6'd1, 4'b1100, 1'b1, d_c, 1'b0);
        beat(6'd1, 4'b1101, 1'b0, d_d, 1'b0);
        tick();
        chk("t5_wr", line_wr, 1'b1);
        chk("t5_ack", ack, 1'b1);
        chk("t5_err", line_err, 1'b1);
        chk("t5_vadr", line_vadr, 32'h0000_30C0);
        chk("t5_dat", line_dat, {d_d, d_c});
        tick(); tick();
        beat(6'd1, 4'b1100, 1'b0, d_e, 1'b0);
        beat(6'd1, 4'b0110, 1'b0, d_e, 1'b1);   // flush wins over a countable beat
        beat(6'd1, 4'b1101, 1'b0, d_f, 1'b0);
        no_write(6, "t5_flush_no_write");
        chk("t5_flush_drop", drop_cnt, 8'd3);
        flush = 1'b1; tick(); flush = 1'b0;
        // flush during the selection cycle suppresses the pick
        beat(6'd1, 4'b0100, 1'b0, d_a, 1'b0);
        beat(6'd1, 4'b0101, 1'b0, d_b, 1'b0);
        flush = 1'b1; tick(); flush = 1'b0;
        no_write(5, "t5_flush_sel");

        // T6: reset mid-collection, then drop counter saturation
        beat(6'd1, 4'b0000, 1'b0, d_a, 1'b0);
        rst = 1'b1; tick(); rst = 1'b0;
        beat(6'd1, 4'b0001, 1'b0, d_b, 1'b0);
        no_write(5, "t6_rst_no_write");
        chk("t6_rst_drop", drop_cnt, 8'd0);
        resp_v = 1'b1; resp_core = 6'd1; resp_channel = 6'd0; resp_tranid = 4'b0010;
        repeat (300) tick();
        resp_v = 1'b0;
        tick();
        chk("t6_drop_sat", drop_cnt, 8'hFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
